// File: rtl/conv_window_gen_pkg.sv
// Shared definitions for the convolution window generator.
// - FSM state encoding
// - Geometry helpers: output dimension, kernel span, line-buffer depth
// - Index-width and tap-index helpers
package conv_window_gen_pkg;

  typedef enum logic [1:0] {
    StFill,
    StAssemble,
    StPresent,
    StDone
  } cwg_state_e;

  // Number of output positions along one axis.
  function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k,
                                          input int unsigned d, input int unsigned p,
                                          input int unsigned s);
    return (in_dim + 2 * p - d * (k - 1) - 1) / s + 1;
  endfunction

  // Input rows/columns covered by one dilated kernel.
  function automatic int unsigned span(input int unsigned k, input int unsigned d);
    return (k - 1) * d + 1;
  endfunction

  // One row being written while a full kernel span is being read.
  function automatic int unsigned buf_rows(input int unsigned k, input int unsigned d);
    return span(k, d) + 1;
  endfunction

  // Counter/index width for values 0..n-1, never zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned tap_index(input int unsigned kr, input int unsigned kc,
                                            input int unsigned k1);
    return kr * k1 + kc;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Circular line buffer: ROWS rows of WIDTH pixels, DATA_W bits per pixel.
// - One write port (row slot, column).
// - RD_PORTS read ports sharing one column address, each with its own row slot.
// - Registered read: data appears the cycle after rd_en.
// Contents are not reset.
module conv_line_buffer
  import conv_window_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = 513,
  parameter int unsigned ROWS     = 6,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned RD_PORTS = 3
) (
  input  logic                                     clk,
  input  logic                                     wr_en,
  input  logic [idx_w(ROWS)-1:0]                   wr_row,
  input  logic [idx_w(WIDTH)-1:0]                  wr_col,
  input  logic [DATA_W-1:0]                        wr_data,
  input  logic                                     rd_en,
  input  logic [RD_PORTS-1:0][idx_w(ROWS)-1:0]     rd_row,
  input  logic [idx_w(WIDTH)-1:0]                  rd_col,
  output logic [RD_PORTS-1:0][DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] mem [ROWS][WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      for (int k = 0; k < RD_PORTS; k++) begin
        rd_data[k] <= mem[rd_row[k]][rd_col];
      end
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Convolution window generator feeding an input-channel-parallel PE.
// - i_data/i_valid/i_ready : raster-order pixel stream, IN_CHANNEL bytes per pixel.
// - o_data/o_valid         : one dilated/padded/strided window, tap t = kr*KERNEL_1+kc,
//                            channel c at byte t*IN_CHANNEL+c; held until pe_ack.
// - pe_ready               : observed only.
// - pe_ack                 : PE has latched o_data.
// - o_frame_done           : one-cycle pulse after the last window of a frame is acked
//                            and the whole frame has been accepted.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 513,
  parameter int unsigned IN_HEIGHT  = 257,
  parameter int unsigned IN_CHANNEL = 3,
  parameter int unsigned KERNEL_0   = 3,
  parameter int unsigned KERNEL_1   = 3,
  parameter int unsigned DILATION_0 = 2,
  parameter int unsigned DILATION_1 = 2,
  parameter int unsigned PADDING_0  = 2,
  parameter int unsigned PADDING_1  = 2,
  parameter int unsigned STRIDE_0   = 1,
  parameter int unsigned STRIDE_1   = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [8*IN_CHANNEL-1:0]                   i_data,
  input  logic                                      i_valid,
  output logic                                      i_ready,
  output logic [8*IN_CHANNEL*KERNEL_0*KERNEL_1-1:0] o_data,
  output logic                                      o_valid,
  input  logic                                      pe_ready,
  input  logic                                      pe_ack,
  output logic                                      o_frame_done
);

  localparam int unsigned ChW     = 8 * IN_CHANNEL;
  localparam int unsigned WinW    = ChW * KERNEL_0 * KERNEL_1;
  localparam int unsigned OutH    = out_dim(IN_HEIGHT, KERNEL_0, DILATION_0, PADDING_0, STRIDE_0);
  localparam int unsigned OutW    = out_dim(IN_WIDTH, KERNEL_1, DILATION_1, PADDING_1, STRIDE_1);
  localparam int unsigned Span0   = span(KERNEL_0, DILATION_0);
  localparam int unsigned BufRows = buf_rows(KERNEL_0, DILATION_0);
  localparam int unsigned ColW    = idx_w(IN_WIDTH);
  localparam int unsigned RowCntW = idx_w(IN_HEIGHT + 1);
  localparam int unsigned SlotW   = idx_w(BufRows);
  localparam int unsigned OyW     = idx_w(OutH);
  localparam int unsigned OxW     = idx_w(OutW);
  localparam int unsigned KcW     = idx_w(KERNEL_1 + 1);

  cwg_state_e           state_q;
  logic [ColW-1:0]      wr_col_q;
  logic [RowCntW-1:0]   wr_row_q;   // absolute input row being written, IN_HEIGHT when full
  logic [SlotW-1:0]     wr_slot_q;  // wr_row_q modulo BufRows
  logic [OyW-1:0]       oy_q;
  logic [OxW-1:0]       ox_q;
  logic [KcW-1:0]       kc_q;       // ASSEMBLE step: read column kc_q, capture column kc_q-1
  logic                 valid_q;
  logic                 done_q;
  logic                 xok_q;      // column of the in-flight read lies inside the frame
  logic [WinW-1:0]      win_q;
  logic [WinW-1:0]      win_d;

  int                   top_y;
  int                   need_cur;
  int                   need_next;
  logic                 frame_full;
  logic                 row_ready;
  logic                 next_row_ready;
  logic                 overwrite_block;
  logic                 in_fire;
  logic                 last_win;
  logic                 clear;
  logic                 rd_en;
  logic                 rd_xok;
  logic [ColW-1:0]      rd_col;
  logic [KERNEL_0-1:0]  yok;
  logic [KERNEL_0-1:0][SlotW-1:0] rd_slot;
  logic [KERNEL_0-1:0][ChW-1:0]   rd_data;
  logic                 unused_pe_ready;

  assign unused_pe_ready = pe_ready;

  // Row bookkeeping for the current output row.
  always_comb begin
    top_y     = int'(oy_q) * int'(STRIDE_0) - int'(PADDING_0);
    need_cur  = top_y + int'(Span0) - 1;
    need_next = need_cur + int'(STRIDE_0);
    if (need_cur > int'(IN_HEIGHT) - 1) need_cur = int'(IN_HEIGHT) - 1;
    if (need_next > int'(IN_HEIGHT) - 1) need_next = int'(IN_HEIGHT) - 1;
    frame_full     = (wr_row_q == RowCntW'(IN_HEIGHT));
    row_ready      = int'(wr_row_q) > need_cur;
    next_row_ready = int'(wr_row_q) > need_next;
    // The next write row reuses the slot of row wr_row-BufRows; hold off while that row
    // is still part of the current window. Once the last window is out nothing is read.
    overwrite_block = (int'(wr_row_q) >= int'(BufRows)) &&
                      (int'(wr_row_q) - int'(BufRows) >= top_y);
    last_win = (oy_q == OyW'(OutH - 1)) && (ox_q == OxW'(OutW - 1));
    clear    = (state_q == StDone) && frame_full;
  end

  assign i_ready = rst_n && !frame_full && ((state_q == StDone) || !overwrite_block);
  assign in_fire = i_valid && i_ready;

  // Line-buffer read addressing. A readable row y satisfies wr_row-BufRows <= y < wr_row,
  // so its slot is wr_slot stepped back by (wr_row - y).
  always_comb begin
    int y_row;
    int s_row;
    int x_col;
    y_row = 0;
    s_row = 0;
    for (int kr = 0; kr < int'(KERNEL_0); kr++) begin
      y_row   = top_y + kr * int'(DILATION_0);
      yok[kr] = (y_row >= 0) && (y_row < int'(IN_HEIGHT));
      s_row   = int'(wr_slot_q) - (int'(wr_row_q) - y_row);
      if (s_row < 0) s_row = s_row + int'(BufRows);
      rd_slot[kr] = yok[kr] ? SlotW'(s_row) : '0;
    end
    x_col  = int'(ox_q) * int'(STRIDE_1) - int'(PADDING_1) + int'(kc_q) * int'(DILATION_1);
    rd_xok = (kc_q < KcW'(KERNEL_1)) && (x_col >= 0) && (x_col < int'(IN_WIDTH));
    rd_col = rd_xok ? ColW'(x_col) : '0;
    rd_en  = (state_q == StAssemble) && (kc_q < KcW'(KERNEL_1));
  end

  // Capture the column read on the previous cycle; out-of-frame taps become zero.
  always_comb begin
    win_d = win_q;
    if (state_q == StAssemble) begin
      for (int kr = 0; kr < int'(KERNEL_0); kr++) begin
        for (int kc = 0; kc < int'(KERNEL_1); kc++) begin
          if (kc_q == KcW'(kc + 1)) begin
            win_d[tap_index(kr, kc, KERNEL_1)*ChW +: ChW] =
                (xok_q && yok[kr]) ? rd_data[kr] : '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFill;
      wr_col_q  <= '0;
      wr_row_q  <= '0;
      wr_slot_q <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      kc_q      <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      xok_q     <= 1'b0;
      win_q     <= '0;
    end else begin
      done_q <= 1'b0;
      xok_q  <= rd_xok;
      win_q  <= win_d;

      if (clear) begin
        wr_col_q  <= '0;
        wr_row_q  <= '0;
        wr_slot_q <= '0;
      end else if (in_fire) begin
        if (wr_col_q == ColW'(IN_WIDTH - 1)) begin
          wr_col_q  <= '0;
          wr_row_q  <= wr_row_q + RowCntW'(1);
          wr_slot_q <= (wr_slot_q == SlotW'(BufRows - 1)) ? '0 : wr_slot_q + SlotW'(1);
        end else begin
          wr_col_q <= wr_col_q + ColW'(1);
        end
      end

      unique case (state_q)
        StFill: begin
          if (row_ready) begin
            state_q <= StAssemble;
            kc_q    <= '0;
          end
        end
        StAssemble: begin
          if (kc_q == KcW'(KERNEL_1)) begin
            state_q <= StPresent;
            valid_q <= 1'b1;
            kc_q    <= '0;
          end else begin
            kc_q <= kc_q + KcW'(1);
          end
        end
        StPresent: begin
          if (pe_ack) begin
            valid_q <= 1'b0;
            if (last_win) begin
              state_q <= StDone;
            end else if (ox_q != OxW'(OutW - 1)) begin
              ox_q    <= ox_q + OxW'(1);
              state_q <= StAssemble;
            end else begin
              ox_q    <= '0;
              oy_q    <= oy_q + OyW'(1);
              state_q <= next_row_ready ? StAssemble : StFill;
            end
          end
        end
        StDone: begin
          // Wait for any trailing input rows no window needed before closing the frame.
          if (frame_full) begin
            done_q  <= 1'b1;
            oy_q    <= '0;
            ox_q    <= '0;
            state_q <= StFill;
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign o_data       = win_q;
  assign o_valid      = valid_q;
  assign o_frame_done = done_q;

  conv_line_buffer #(
    .WIDTH    (IN_WIDTH),
    .ROWS     (BufRows),
    .DATA_W   (ChW),
    .RD_PORTS (KERNEL_0)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_row  (wr_slot_q),
    .wr_col  (wr_col_q),
    .wr_data (i_data),
    .rd_en   (rd_en),
    .rd_row  (rd_slot),
    .rd_col  (rd_col),
    .rd_data (rd_data)
  );

endmodule
